md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers. Sits beside the main ALU in the EX stage and is driven by a pre-decoded op code rather than the raw instruction.
- Multiplies, including the accumulate and subtract forms, use a fixed-latency model.
- Divides use a true iterative radix-2 restoring divider, one quotient bit per cycle.
- HI/LO are committed only when an operation completes, so an in-flight operation never exposes partial results.

Parameters:
- WIDTH, 32: operand, HI and LO width. Minimum 4.
- MUL_LAT, 5: busy cycles for the multiply-class ops. Minimum 1.
- DIV_LAT: not a parameter. Divide busy length is fixed at WIDTH+1 cycles: WIDTH iterations plus 1 sign-fixup cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  op valid this cycle.
- op  in  4  operation code; only sampled when start=1.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse on the cycle after HI/LO commit.
- cancel  in  1  only when MD_CANCEL_EN is defined.

Behaviour:
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU. Codes 11-15 are NOP.
- Reset (async) state: hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept rule: start=1 in IDLE is accepted at the rising edge. start=1 while busy=1 is ignored entirely, including MTHI/MTLO. The pipeline is responsible for stalling.
- MTHI/MTLO: accepted in IDLE, write hi/lo with a at that edge. busy stays 0; done stays 0.
- Multiply-class ops (1,2,7,8,9,10):
  - Operands and op are latched at accept; the 2*WIDTH result is computed from the latched values.
  - FSM goes to MUL; busy=1 for exactly MUL_LAT cycles, starting the cycle after accept.
  - At the edge ending the last busy cycle: {hi,lo} is written, busy falls, done=1 for the following cycle.
- Multiply arithmetic:
  - MULT/MADD/MSUB are signed. MULTU/MADDU/MSUBU are unsigned (zero-extended).
  - MADD*: {hi,lo} <= {hi,lo} + product. MSUB*: {hi,lo} <= {hi,lo} - product. Both are modulo 2^(2*WIDTH), using the HI/LO value at commit time.
- Divide ops (3,4):
  - At accept: |a| and |b| are latched (raw values for DIVU), plus the quotient and remainder signs.
  - DIV state runs WIDTH iterations; FIX then applies signs. Busy length is WIDTH+1 cycles.
  - Commit at the end of FIX: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide boundary cases:
  - b=0: no trap. lo = all ones, hi = a. Full latency is still taken.
  - Signed overflow (a = -2^(WIDTH-1), b = -1): lo = a, hi = 0.
- Reset mid-operation: the operation is aborted immediately, hi/lo cleared to 0, busy=0, done=0.
- hi/lo outputs: driven directly from the registers. They are stable for the whole busy period and hold their pre-op value until commit.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - The cancel port exists.
  - cancel=1 while busy aborts the op at that edge: FSM to IDLE, busy=0 next cycle, no commit, no done pulse, hi/lo unchanged.
  - cancel=1 in IDLE, or on the same edge as an accept, suppresses that accept.
- Not defined: the port is absent and every accepted op runs to completion.

Test Plan:
- MULT, WIDTH=32, a=0xFFFFFFFD (-3), b=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, one done pulse.
- MULTU, same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> busy 33 cycles, lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO a=0xFFFFFFFF, MTHI a=0, then MADD a=1, b=1 -> hi=1, lo=0. Then MSUBU a=1, b=1 -> hi=0, lo=0xFFFFFFFF.
- Start DIVU, then on busy cycle 3 present MTHI a=0x1234 with start=1 -> ignored, hi ends at the remainder. Assert reset on busy cycle 10 of another DIVU -> hi=lo=0 and busy=0 immediately. With MD_CANCEL_EN defined, cancel on MULT busy cycle 2 -> hi/lo unchanged and no done pulse.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO result registers.
//
// Sits beside the main ALU in EX and is driven by a pre-decoded op code.
// Multiply-class ops (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) take a fixed MUL_LAT
// busy cycles. Divides (DIV/DIVU) run a radix-2 restoring divider, one
// quotient bit per cycle, followed by one sign-fixup cycle (WIDTH+1 cycles).
// HI/LO are written only when an operation completes.
//
// Optional feature macro: MD_CANCEL_EN adds the cancel input, which aborts an
// in-flight op (no commit, no done) or suppresses an accept in IDLE.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset, clears all state
//   start   in   op valid this cycle (accepted only in IDLE)
//   op      in   4-bit operation code, sampled only when start=1
//   a, b    in   WIDTH-bit operands (rs, rt)
//   cancel  in   abort / accept suppression (only with MD_CANCEL_EN)
//   hi, lo  out  HI and LO registers
//   busy    out  an operation is in flight
//   done    out  one-cycle pulse on the cycle after HI/LO commit
module md_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MD_CANCEL_EN
    input  logic             cancel,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
    localparam logic [3:0] OpMsub  = 4'd9;
    localparam logic [3:0] OpMsubu = 4'd10;

    // One counter serves both the multiply latency and the divide iterations.
    localparam int unsigned CntMax = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  opa_q;     // raw operand A (also HI result for divide by zero)
    logic [WIDTH-1:0]  opb_q;     // raw operand B
    logic [WIDTH-1:0]  quo_q;     // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0]  rem_q;     // partial remainder
    logic [WIDTH-1:0]  dvs_q;     // divisor magnitude
    logic              q_neg_q;
    logic              r_neg_q;
    logic              dz_q;      // divide by zero
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              busy_q;
    logic              done_q;

    logic              cancel_w;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Accept-time operand conditioning for divides
    // ------------------------------------------------------------------
    logic              div_signed;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;

    always_comb begin
        div_signed = (op == OpDiv);
        abs_a      = (div_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b      = (div_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // ------------------------------------------------------------------
    // Multiply datapath, evaluated from latched operands
    // ------------------------------------------------------------------
    logic                 mul_signed;
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   mul_res;

    always_comb begin
        mul_signed = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub);
        ext_a      = mul_signed ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
        ext_b      = mul_signed ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
        // Low 2*WIDTH bits of the sign-extended product are the exact signed result.
        product    = ext_a * ext_b;
        case (op_q)
            OpMadd, OpMaddu: mul_res = {hi_q, lo_q} + product;
            OpMsub, OpMsubu: mul_res = {hi_q, lo_q} - product;
            default:         mul_res = product;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divider step
    // ------------------------------------------------------------------
    logic [WIDTH:0]    rem_shift;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_nxt;
    logic [WIDTH-1:0]  quo_nxt;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        // When the subtraction is kept the result is below the divisor, so it fits WIDTH bits.
        rem_nxt   = rem_ge ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], rem_ge};
    end

    // ------------------------------------------------------------------
    // Sign fixup and divide-by-zero result
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  fix_hi;
    logic [WIDTH-1:0]  fix_lo;

    always_comb begin
        if (dz_q) begin
            fix_lo = '1;
            fix_hi = opa_q;
        end else begin
            // Signed overflow (-2^(W-1) / -1) falls out naturally: |a| = 2^(W-1),
            // quotient sign positive, so LO = 2^(W-1) = a and HI = 0.
            fix_lo = q_neg_q ? (~quo_q + 1'b1) : quo_q;
            fix_hi = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpNop;
            opa_q   <= '0;
            opb_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && !cancel_w) begin
                        case (op)
                            OpMthi: hi_q <= a;
                            OpMtlo: lo_q <= a;
                            OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: begin
                                op_q    <= op;
                                opa_q   <= a;
                                opb_q   <= b;
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= StMul;
                            end
                            OpDiv, OpDivu: begin
                                op_q    <= op;
                                opa_q   <= a;
                                opb_q   <= b;
                                quo_q   <= abs_a;
                                dvs_q   <= abs_b;
                                rem_q   <= '0;
                                q_neg_q <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_neg_q <= div_signed && a[WIDTH-1];
                                dz_q    <= (b == '0);
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= StDiv;
                            end
                            default: ;
                        endcase
                    end
                end

                StMul: begin
                    if (cancel_w) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == MulLast) begin
                        {hi_q, lo_q} <= mul_res;
                        done_q       <= 1'b1;
                        cnt_q        <= '0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StDiv: begin
                    if (cancel_w) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        quo_q <= quo_nxt;
                        rem_q <= rem_nxt;
                        if (cnt_q == DivLast) begin
                            cnt_q   <= '0;
                            state_q <= StFix;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                StFix: begin
                    if (!cancel_w) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit (WIDTH=32, MUL_LAT=5).
module tb_md_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
`ifdef MD_CANCEL_EN
    logic         cancel;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    md_unit #(
        .WIDTH   (W),
        .MUL_LAT (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MD_CANCEL_EN
        .cancel (cancel),
`endif
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one op for a single rising edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
    endtask

    // Counts busy cycles (bounded), leaves us at the first negedge with busy low.
    task automatic wait_idle(input int start_n, output int cnt);
        cnt = start_n;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_cyc,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int c;
        issue(o, x, y);
        wait_idle(0, c);
        check({tag, " busy_cycles"}, 64'(c), 64'(exp_cyc));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, " done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
`ifdef MD_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Multiplies
        run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu", 4'd2, 32'hFFFF_FFFD, 32'd7, 5, 32'h0000_0006, 32'hFFFF_FFEB);

        // Divides
        run_op("divu", 4'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_by0", 4'd3, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
        run_op("div_neg_by0", 4'd3, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

        // MTLO / MTHI then accumulate forms
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        check("mtlo lo", 64'(lo), 64'hFFFF_FFFF);
        check("mtlo busy", 64'(busy), 64'd0);
        check("mtlo done", 64'(done), 64'd0);
        issue(4'd5, 32'd0, 32'd0);
        check("mthi hi", 64'(hi), 64'd0);
        run_op("madd", 4'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        run_op("msubu", 4'd10, 32'd1, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);

        // MTHI presented while a divide is busy must be ignored
        issue(4'd4, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        issue(4'd5, 32'h0000_1234, 32'd0);
        check("busy_mthi hi_hold", 64'(hi), 64'd0);
        check("busy_mthi lo_hold", 64'(lo), 64'hFFFF_FFFF);
        wait_idle(3, n);
        check("busy_mthi busy_cycles", 64'(n), 64'd33);
        check("busy_mthi done", 64'(done), 64'd1);
        check("busy_mthi hi", 64'(hi), 64'd2);
        check("busy_mthi lo", 64'(lo), 64'd14);
        @(negedge clk);

        // NOP and unused codes do nothing
        issue(4'd0, 32'hDEAD_BEEF, 32'd1);
        check("nop busy", 64'(busy), 64'd0);
        issue(4'd12, 32'hDEAD_BEEF, 32'd1);
        check("op12 busy", 64'(busy), 64'd0);
        check("op12 hi", 64'(hi), 64'd2);
        check("op12 lo", 64'(lo), 64'd14);

        // Reset on busy cycle 10 of a divide
        issue(4'd4, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("pre_reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset busy", 64'(busy), 64'd0);

`ifdef MD_CANCEL_EN
        run_op("mult_setup", 4'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel done", 64'(done), 64'd0);
        check("cancel hi", 64'(hi), 64'd0);
        check("cancel lo", 64'(lo), 64'd12);
        @(negedge clk);
        check("cancel done_later", 64'(done), 64'd0);
        cancel = 1'b1;
        issue(4'd6, 32'd5, 32'd0);
        cancel = 1'b0;
        check("cancel_accept lo", 64'(lo), 64'd12);
        check("cancel_accept busy", 64'(busy), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
